// File: rtl/dlx_pkg.sv
// Shared DLX definitions: datapath width, ALU opcodes used by both decode and
// execute, and the EX/MEM interstage record.
package dlx_pkg;

  localparam int DLX_WIDTH = 32;

  typedef enum logic [4:0] {
    ALU_AND   = 5'h00,
    ALU_OR    = 5'h01,
    ALU_ADD   = 5'h02,
    ALU_ADDU  = 5'h03,
    ALU_XOR   = 5'h04,
    ALU_SUB   = 5'h06,
    ALU_SUBU  = 5'h07,
    ALU_SLL   = 5'h08,
    ALU_SRL   = 5'h09,
    ALU_SRA   = 5'h0A,
    ALU_SLT   = 5'h0B,
    ALU_SGT   = 5'h0C,
    ALU_SLE   = 5'h0D,
    ALU_SGE   = 5'h0E,
    ALU_SEQ   = 5'h0F,
    ALU_SNE   = 5'h10,
    ALU_LHI   = 5'h11,
    ALU_PASSB = 5'h12,
    ALU_SLTU  = 5'h13,
    ALU_SGTU  = 5'h14
  } alu_op_e;

  // All-zero record is a bubble: no register write, no store, rd=0.
  typedef struct packed {
    logic [DLX_WIDTH-1:0] result;
    logic [DLX_WIDTH-1:0] store_data;
    logic                 mem_to_reg;
    logic                 reg_write;
    logic                 mem_write;
    logic [4:0]           rd;
  } ex_mem_t;

endpackage

// File: rtl/dlx_alu.sv
// Purely combinational DLX ALU. Unknown opcodes return zero with all flags
// clear, so Zero still reads 1 for them.
module dlx_alu
  import dlx_pkg::*;
#(
  parameter int WIDTH = DLX_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic             set_o
);

  alu_op_e          op;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [4:0]       shamt;
  logic             add_ovf;
  logic             sub_ovf;
  logic             lt_s;
  logic             lt_u;
  logic             eq;

  assign op    = alu_op_e'(op_i);
  assign shamt = b_i[4:0];

  // Subtraction as A + ~B + 1 so the carry reads 1 when no borrow occurs.
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

  assign add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1]  != a_i[WIDTH-1]);
  assign sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);

  assign lt_s = $signed(a_i) < $signed(b_i);
  assign lt_u = a_i < b_i;
  assign eq   = a_i == b_i;

  always_comb begin
    result_o   = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    set_o      = 1'b0;
    case (op)
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_ADD: begin
        result_o   = sum[WIDTH-1:0];
        carry_o    = sum[WIDTH];
        overflow_o = add_ovf;
      end
      ALU_ADDU: begin
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
      end
      ALU_SUB: begin
        result_o   = diff[WIDTH-1:0];
        carry_o    = diff[WIDTH];
        overflow_o = sub_ovf;
      end
      ALU_SUBU: begin
        result_o = diff[WIDTH-1:0];
        carry_o  = diff[WIDTH];
      end
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SRL:   result_o = a_i >> shamt;
      ALU_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SLT:   set_o = lt_s;
      ALU_SGT:   set_o = !lt_s && !eq;
      ALU_SLE:   set_o = lt_s || eq;
      ALU_SGE:   set_o = !lt_s;
      ALU_SEQ:   set_o = eq;
      ALU_SNE:   set_o = !eq;
      ALU_LHI:   result_o = b_i << 16;
      ALU_PASSB: result_o = b_i;
      ALU_SLTU:  set_o = lt_u;
      ALU_SGTU:  set_o = !lt_u && !eq;
      default:   result_o = '0;
    endcase
    // Compare ops leave result at zero above; the condition lands in bit 0.
    result_o = result_o | {{(WIDTH-1){1'b0}}, set_o};
  end

  assign zero_o = ~|result_o;

endmodule

// File: rtl/ex_pipe_stage.sv
// DLX execute stage: combinational ALU feeding ID-stage forwarding, plus the
// EX/MEM register, which loads on the falling clock edge like the rest of the pipe.
module ex_pipe_stage
  import dlx_pkg::*;
#(
  parameter int WIDTH = DLX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Op_ex,
  input  logic             MemtoReg_ex,
  input  logic             RegWrite_ex,
  input  logic             MemWrite_ex,
  input  logic [4:0]       towrite,
  input  logic [WIDTH-1:0] mem_data,
  output logic [WIDTH-1:0] Result_ex,
  output logic             Carryout,
  output logic             Overflow,
  output logic             Zero,
  output logic             Set,
  output logic [WIDTH-1:0] Result_mem,
  output logic [WIDTH-1:0] mem_data_ex,
  output logic             MemtoReg_mem,
  output logic             RegWrite_mem,
  output logic             MemWrite_mem,
  output logic [4:0]       towrite_ex
);

  ex_mem_t ex_mem_d;
  ex_mem_t ex_mem_q;

  dlx_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i        (A),
    .b_i        (B),
    .op_i       (Op_ex),
    .result_o   (Result_ex),
    .carry_o    (Carryout),
    .overflow_o (Overflow),
    .zero_o     (Zero),
    .set_o      (Set)
  );

  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.result     = Result_ex;
    ex_mem_d.store_data = mem_data;
    ex_mem_d.mem_to_reg = MemtoReg_ex;
    ex_mem_d.reg_write  = RegWrite_ex;
    ex_mem_d.mem_write  = MemWrite_ex;
    ex_mem_d.rd         = towrite;
  end

  // No stall/flush: upstream injects bubbles by clearing the write enables.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign Result_mem   = ex_mem_q.result;
  assign mem_data_ex  = ex_mem_q.store_data;
  assign MemtoReg_mem = ex_mem_q.mem_to_reg;
  assign RegWrite_mem = ex_mem_q.reg_write;
  assign MemWrite_mem = ex_mem_q.mem_write;
  assign towrite_ex   = ex_mem_q.rd;

endmodule

// File: tb/tb_ex_pipe_stage.sv
// Directed bench for ex_pipe_stage: ALU vectors with hand-computed results and
// flags, then falling-edge capture and asynchronous reset of the EX/MEM register.
module tb_ex_pipe_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  Op_ex;
  logic        MemtoReg_ex;
  logic        RegWrite_ex;
  logic        MemWrite_ex;
  logic [4:0]  towrite;
  logic [31:0] mem_data;
  logic [31:0] Result_ex;
  logic        Carryout;
  logic        Overflow;
  logic        Zero;
  logic        Set;
  logic [31:0] Result_mem;
  logic [31:0] mem_data_ex;
  logic        MemtoReg_mem;
  logic        RegWrite_mem;
  logic        MemWrite_mem;
  logic [4:0]  towrite_ex;

  int total = 0;
  int bad   = 0;

  ex_pipe_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .A            (A),
    .B            (B),
    .Op_ex        (Op_ex),
    .MemtoReg_ex  (MemtoReg_ex),
    .RegWrite_ex  (RegWrite_ex),
    .MemWrite_ex  (MemWrite_ex),
    .towrite      (towrite),
    .mem_data     (mem_data),
    .Result_ex    (Result_ex),
    .Carryout     (Carryout),
    .Overflow     (Overflow),
    .Zero         (Zero),
    .Set          (Set),
    .Result_mem   (Result_mem),
    .mem_data_ex  (mem_data_ex),
    .MemtoReg_mem (MemtoReg_mem),
    .RegWrite_mem (RegWrite_mem),
    .MemWrite_mem (MemWrite_mem),
    .towrite_ex   (towrite_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU vector: op, A, B, expected {result, C, V, Z, S}
  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        s;
  } alu_vec_t;

  task automatic test_reset();
    rst_n = 1'b0;
    A = 32'h0; B = 32'h0; Op_ex = 5'h00;
    MemtoReg_ex = 1'b1; RegWrite_ex = 1'b1; MemWrite_ex = 1'b1;
    towrite = 5'd9; mem_data = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({Result_mem, mem_data_ex, MemtoReg_mem, RegWrite_mem, MemWrite_mem, towrite_ex} !== 72'h0) begin
      bad++;
      $display("FAIL reset_regs got res=%h st=%h m2r=%b rw=%b mw=%b rd=%0d want all 0",
               Result_mem, mem_data_ex, MemtoReg_mem, RegWrite_mem, MemWrite_mem, towrite_ex);
    end
    // Combinational path must work while reset is held.
    A = 32'h10; B = 32'h20; Op_ex = 5'h02;
    #1;
    total++;
    if (Result_ex !== 32'h30) begin
      bad++;
      $display("FAIL reset_comb got %h want 00000030", Result_ex);
    end
    MemtoReg_ex = 1'b0; RegWrite_ex = 1'b0; MemWrite_ex = 1'b0;
    towrite = 5'd0; mem_data = 32'h0;
  endtask

  task automatic run_alu_vecs(input alu_vec_t vecs[]);
    foreach (vecs[i]) begin
      Op_ex = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
      #1;
      total++;
      if ({Result_ex, Carryout, Overflow, Zero, Set} !==
          {vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].s}) begin
        bad++;
        $display("FAIL %s got res=%h c=%b v=%b z=%b s=%b want res=%h c=%b v=%b z=%b s=%b",
                 vecs[i].name, Result_ex, Carryout, Overflow, Zero, Set,
                 vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].s);
      end
    end
  endtask

  task automatic test_arith();
    alu_vec_t v[] = '{
      '{"add_ovf",   5'h02, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0},
      '{"add_carry", 5'h02, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1'b1, 1'b0},
      '{"addu_novf", 5'h03, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0},
      '{"subu_zero", 5'h07, 32'h5,         32'h5,         32'h0,         1'b1, 1'b0, 1'b1, 1'b0},
      '{"sub_borrow",5'h06, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0},
      '{"sub_ovf",   5'h06, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0},
      '{"and",       5'h00, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{"or",        5'h01, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{"xor",       5'h04, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 1'b0, 1'b0, 1'b0},
      '{"passb",     5'h12, 32'h1234_5678, 32'h0000_0055, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b0}
    };
    run_alu_vecs(v);
  endtask

  task automatic test_shift();
    alu_vec_t v[] = '{
      '{"sra",      5'h0A, 32'h8000_0010, 32'h4,         32'hF800_0001, 1'b0, 1'b0, 1'b0, 1'b0},
      '{"srl",      5'h09, 32'h8000_0010, 32'h4,         32'h0800_0001, 1'b0, 1'b0, 1'b0, 1'b0},
      '{"sll_mask", 5'h08, 32'h8000_0010, 32'h24,        32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0},
      '{"sll_zero", 5'h08, 32'h8000_0010, 32'h20,        32'h8000_0010, 1'b0, 1'b0, 1'b0, 1'b0},
      '{"lhi",      5'h11, 32'hFFFF_FFFF, 32'h1234,      32'h1234_0000, 1'b0, 1'b0, 1'b0, 1'b0},
      '{"lhi_hi",   5'h11, 32'h0,         32'hABCD_1234, 32'h1234_0000, 1'b0, 1'b0, 1'b0, 1'b0}
    };
    run_alu_vecs(v);
  endtask

  task automatic test_compare();
    alu_vec_t v[] = '{
      '{"slt",  5'h0B, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{"sltu", 5'h13, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{"sgtu", 5'h14, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{"sgt",  5'h0C, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{"sle",  5'h0D, 32'h3,         32'h3, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{"sge",  5'h0E, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{"seq",  5'h0F, 32'h3,         32'h3, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{"sne",  5'h10, 32'h3,         32'h3, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}
    };
    run_alu_vecs(v);
  endtask

  task automatic test_undef();
    alu_vec_t v[] = '{
      '{"undef_1f", 5'h1F, 32'h5,         32'h7,         32'h0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{"undef_05", 5'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{"undef_15", 5'h15, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}
    };
    run_alu_vecs(v);
  endtask

  task automatic test_pipeline();
    rst_n = 1'b1;
    @(posedge clk); #1;
    Op_ex = 5'h02; A = 32'h100; B = 32'h4;
    RegWrite_ex = 1'b1; MemtoReg_ex = 1'b1; MemWrite_ex = 1'b0;
    towrite = 5'd7; mem_data = 32'hDEAD_BEEF;
    #1;
    total++;
    if ({Result_mem, RegWrite_mem, towrite_ex} !== {32'h0, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL pipe_before_edge got res=%h rw=%b rd=%0d want 00000000/0/0",
               Result_mem, RegWrite_mem, towrite_ex);
    end
    @(negedge clk); #1;
    total++;
    if ({Result_mem, mem_data_ex, MemtoReg_mem, RegWrite_mem, MemWrite_mem, towrite_ex} !==
        {32'h104, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 5'd7}) begin
      bad++;
      $display("FAIL pipe_capture got res=%h st=%h m2r=%b rw=%b mw=%b rd=%0d want 00000104/deadbeef/1/1/0/7",
               Result_mem, mem_data_ex, MemtoReg_mem, RegWrite_mem, MemWrite_mem, towrite_ex);
    end
    // New inputs must not appear across a rising edge.
    Op_ex = 5'h06; A = 32'h50; B = 32'h10;
    RegWrite_ex = 1'b0; MemtoReg_ex = 1'b0; MemWrite_ex = 1'b1;
    towrite = 5'd3; mem_data = 32'h0000_CAFE;
    @(posedge clk); #1;
    total++;
    if ({Result_mem, mem_data_ex, MemtoReg_mem, RegWrite_mem, MemWrite_mem, towrite_ex} !==
        {32'h104, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 5'd7}) begin
      bad++;
      $display("FAIL pipe_rise_hold got res=%h st=%h rd=%0d want 00000104/deadbeef/7",
               Result_mem, mem_data_ex, towrite_ex);
    end
    @(negedge clk); #1;
    total++;
    if ({Result_mem, mem_data_ex, MemtoReg_mem, RegWrite_mem, MemWrite_mem, towrite_ex} !==
        {32'h40, 32'h0000_CAFE, 1'b0, 1'b0, 1'b1, 5'd3}) begin
      bad++;
      $display("FAIL pipe_back_to_back got res=%h st=%h m2r=%b rw=%b mw=%b rd=%0d want 00000040/0000cafe/0/0/1/3",
               Result_mem, mem_data_ex, MemtoReg_mem, RegWrite_mem, MemWrite_mem, towrite_ex);
    end
  endtask

  task automatic test_async_reset();
    // Register currently holds SUB/store state from the previous test.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({Result_mem, mem_data_ex, MemtoReg_mem, RegWrite_mem, MemWrite_mem, towrite_ex} !== 72'h0) begin
      bad++;
      $display("FAIL async_clear got res=%h st=%h mw=%b rd=%0d want all 0",
               Result_mem, mem_data_ex, MemWrite_mem, towrite_ex);
    end
    @(negedge clk); #1;
    total++;
    if ({Result_mem, MemWrite_mem, towrite_ex} !== {32'h0, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL reset_hold got res=%h mw=%b rd=%0d want 0/0/0",
               Result_mem, MemWrite_mem, towrite_ex);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    Op_ex = 5'h01; A = 32'hA000_0000; B = 32'h0000_000B;
    RegWrite_ex = 1'b1; MemtoReg_ex = 1'b0; MemWrite_ex = 1'b0;
    towrite = 5'd31; mem_data = 32'h1111_2222;
    #1;
    total++;
    if ({Result_mem, towrite_ex} !== {32'h0, 5'd0}) begin
      bad++;
      $display("FAIL release_no_load got res=%h rd=%0d want 0/0", Result_mem, towrite_ex);
    end
    @(negedge clk); #1;
    total++;
    if ({Result_mem, mem_data_ex, MemtoReg_mem, RegWrite_mem, MemWrite_mem, towrite_ex} !==
        {32'hA000_000B, 32'h1111_2222, 1'b0, 1'b1, 1'b0, 5'd31}) begin
      bad++;
      $display("FAIL release_load got res=%h st=%h m2r=%b rw=%b mw=%b rd=%0d want a000000b/11112222/0/1/0/31",
               Result_mem, mem_data_ex, MemtoReg_mem, RegWrite_mem, MemWrite_mem, towrite_ex);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_compare();
    test_undef();
    test_pipeline();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
